regfile_multiport: RTL and testbench
====================================

# regfile_multiport

Parametrised multi-port integer register file for the core: configurable register count (RV32I/RV32E), data width, number of read ports and two prioritised write ports. It replaces the single-write, two-read register file in the decode/writeback path. It adds optional write-to-read bypass, a hardwired-zero x0, a sequential clear engine with a `ready` flag, and a same-address write-collision flag.

## Interface
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, architectural register count; legal values 16 or 32; x0 is always zero.
- `READ_PORTS`, 2, number of combinational read ports; legal range 1..4.
- `BYPASS`, 1, 1 = a read whose address matches a same-cycle write returns the write data; 0 = it returns the stored value.
- `ADDR_W`, `$clog2(NREGS)`, derived; not overridden.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `clear_req` input 1: one-cycle request to zero the whole file.
- `ready` output 1: file is usable; 0 while clearing.
- `we` input 2: write enables; bit 1 = port 1 (higher priority).
- `waddr` input 2*ADDR_W: write addresses; slice i = port i.
- `wdata` input 2*XLEN: write data; slice i = port i.
- `raddr` input READ_PORTS*ADDR_W: read addresses.
- `rdata` output READ_PORTS*XLEN: read data.
- `collision` output 1: registered; pulses for one cycle after both write ports write the same nonzero address.

## Operation
- FSM states:
  - CLEAR: a counter `clr_idx` runs 1..NREGS-1 and writes zero to `regs[clr_idx]`, one register per cycle.
  - READY: normal operation.
- Reset assertion forces CLEAR with `clr_idx`=1, `ready`=0 and `collision`=0. Array contents are not reset directly.
- CLEAR → READY on the edge that clears `NREGS-1`.
- `clear_req` in READY moves to CLEAR with `clr_idx`=1 on the next edge.
- `clear_req` in CLEAR restarts `clr_idx` at 1.
- In CLEAR:
  - All writes are dropped.
  - All `rdata` slices read 0.
  - `collision` stays 0.
- In READY, writes:
  - Port i writes `wdata[i]` to `waddr[i]` when `we[i]`=1 and `waddr[i]`≠0.
  - If both ports target the same address, port 1's data is stored and `collision` is set for the next cycle.
  - Writes to address 0 are discarded and never raise `collision`.
- In READY, reads:
  - `rdata[j]` = 0 when `raddr[j]`=0.
  - With BYPASS=1: if the address matches an enabled, nonzero write, `rdata[j]` returns that write's data, port 1 taking priority over port 0.
  - Otherwise `rdata[j]` = `regs[raddr[j]]`.
- Addresses ≥ NREGS (possible only with NREGS=16 and a 5-bit source) cannot occur, because ADDR_W=4; upper instruction bits are the decoder's concern.

## Timing
- Read latency: 0 cycles (combinational from `raddr`, the state and, if BYPASS=1, the write ports).
- Write latency: 1 edge; the value is visible on a non-bypassed read in the following cycle.
- Clear duration: NREGS-1 cycles.
  - `ready` rises on the same edge that clears the last register; it is registered.
  - From reset release, the first edge clears x1, and `ready`=1 after edge NREGS-1 (31 for default parameters).
- `collision` is registered and asserts for exactly the one cycle after the colliding edge.
- Reset mid-clear or mid-write: asynchronous return to CLEAR at `clr_idx`=1; any partially cleared contents are re-cleared.
- Reset values: `ready`=0, `collision`=0, every `rdata` slice = 0 (because the FSM is in CLEAR).

## Structure
- Package `regfile_pkg` holds:
  - the state enum (CLEAR, READY);
  - constants `NREGS_RV32I`=32 and `NREGS_RV32E`=16;
  - an address-width helper function.
- Sub-module `regfile_read_port`: one instance per read port, generated `READ_PORTS` times.
  - Inputs: address, state, both write ports, array word.
  - It contains the x0, clear and bypass selection logic.
- Top level holds the array, the FSM, `clr_idx`, the write-priority logic and the `collision` register.

## Test plan
- Reset release, count edges until `ready`=1 → exactly 31 edges (NREGS=32); then every register reads 0 on all ports.
- READY, port 0 writes 0xDEADBEEF to x5, BYPASS=1, `raddr[0]`=5 in the same cycle → `rdata[0]`=0xDEADBEEF in that cycle. Repeat with BYPASS=0 → the old value, then 0xDEADBEEF next cycle.
- Both ports write x7 (port 0 = 0x11, port 1 = 0x22) → x7=0x22 and `collision`=1 for one cycle. Both write x0 → x0 stays 0 and `collision`=0.
- Write x3=0x1234, pulse `clear_req`, attempt a write of x4 during CLEAR → `ready`=0 for 31 cycles, `rdata`=0 throughout, and after `ready` both x3 and x4 read 0.
- Assert `reset` asynchronously mid-clear (`clr_idx`=10) → `ready` drops immediately; after release the full 31-cycle clear repeats.
- NREGS=16, READ_PORTS=4: write x15=0xA5A5A5A5 and read it on all four ports → all four return 0xA5A5A5A5; `ready` asserts after 15 clear edges.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

  localparam int NREGS_RV32I = 32;
  localparam int NREGS_RV32E = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Address width needed to index nregs registers (at least one bit).
  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 forcing, zero output while clearing,
// and optional same-cycle write bypass with port 1 taking priority.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0] i_raddr,
  input  state_t            i_state,
  input  logic [1:0]        i_we,
  input  logic [ADDR_W-1:0] i_waddr0,
  input  logic [ADDR_W-1:0] i_waddr1,
  input  logic [XLEN-1:0]   i_wdata0,
  input  logic [XLEN-1:0]   i_wdata1,
  input  logic [XLEN-1:0]   i_word,
  output logic [XLEN-1:0]   o_rdata
);

  // Select between zero, bypassed write data and the stored word.
  // A nonzero read address implies any matching write address is nonzero too,
  // so writes to x0 can never leak through the bypass.
  always_comb begin
    o_rdata = i_word;
    if (i_state != ST_READY || i_raddr == '0) begin
      o_rdata = '0;
    end else if (BYPASS) begin
      if (i_we[1] && i_waddr1 == i_raddr) begin
        o_rdata = i_wdata1;
      end else if (i_we[0] && i_waddr0 == i_raddr) begin
        o_rdata = i_wdata0;
      end
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port integer register file: hardwired x0, two prioritised write
// ports, READ_PORTS combinational read ports and a sequential clear engine.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | zeroing regs[clr_idx], one per cycle; writes dropped, reads 0
//   ST_READY | normal operation; ready = 1
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = NREGS_RV32I,
  parameter int READ_PORTS = 2,
  parameter bit BYPASS     = 1'b1,
  parameter int ADDR_W     = addr_width(NREGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_req,
  output logic                         ready,
  input  logic [1:0]                   we,
  input  logic [2*ADDR_W-1:0]          waddr,
  input  logic [2*XLEN-1:0]            wdata,
  input  logic [READ_PORTS*ADDR_W-1:0] raddr,
  output logic [READ_PORTS*XLEN-1:0]   rdata,
  output logic                         collision
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_idx;
  logic              r_ready;
  logic              r_collision;
  logic [XLEN-1:0]   r_regs [NREGS];

  logic [ADDR_W-1:0] w_waddr0;
  logic [ADDR_W-1:0] w_waddr1;
  logic [XLEN-1:0]   w_wdata0;
  logic [XLEN-1:0]   w_wdata1;
  logic              w_wr0;
  logic              w_wr1;
  logic              w_same;

  assign w_waddr0 = waddr[ADDR_W-1:0];
  assign w_waddr1 = waddr[2*ADDR_W-1:ADDR_W];
  assign w_wdata0 = wdata[XLEN-1:0];
  assign w_wdata1 = wdata[2*XLEN-1:XLEN];
  assign w_wr0    = we[0] && (w_waddr0 != '0);
  assign w_wr1    = we[1] && (w_waddr1 != '0);
  assign w_same   = w_wr0 && w_wr1 && (w_waddr0 == w_waddr1);

  // Sequencing FSM with clear counter and registered ready/collision.
  // Collision is suppressed on the edge that enters CLEAR so it stays 0 there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_CLEAR;
      r_clr_idx   <= FIRST_IDX;
      r_ready     <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_collision <= 1'b0;
          if (clear_req) begin
            r_clr_idx <= FIRST_IDX;
          end else if (r_clr_idx == LAST_IDX) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end else begin
            r_clr_idx <= r_clr_idx + FIRST_IDX;
          end
        end
        ST_READY: begin
          r_collision <= w_same && !clear_req;
          if (clear_req) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= FIRST_IDX;
            r_ready   <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_clr_idx   <= FIRST_IDX;
          r_ready     <= 1'b0;
          r_collision <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: clear engine while clearing, otherwise both write ports
  // with port 1 winning a same-address write. Contents are deliberately not
  // reset; the clear engine zeroes them after every reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_regs[r_clr_idx] <= '0;
    end else begin
      if (w_wr0 && !w_same) begin
        r_regs[w_waddr0] <= w_wdata0;
      end
      if (w_wr1) begin
        r_regs[w_waddr1] <= w_wdata1;
      end
    end
  end

  assign ready     = r_ready;
  assign collision = r_collision;

  for (genvar j = 0; j < READ_PORTS; j++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    assign w_raddr = raddr[j*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .XLEN  (XLEN),
      .ADDR_W(ADDR_W),
      .BYPASS(BYPASS)
    ) u_rd (
      .i_raddr (w_raddr),
      .i_state (r_state),
      .i_we    (we),
      .i_waddr0(w_waddr0),
      .i_waddr1(w_waddr1),
      .i_wdata0(w_wdata0),
      .i_wdata1(w_wdata1),
      .i_word  (r_regs[w_raddr]),
      .o_rdata (rdata[j*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: DUT A uses the default
// configuration (32 regs, 2 ports, bypass), DUT B is RV32E with 4 ports and
// no bypass. Both share the stimulus (B sees the low 4 address bits).
module tb_regfile_multiport;

  typedef struct packed {
    logic             rdy_a;
    logic             col_a;
    logic [1:0][31:0] rd_a;
    logic             rdy_b;
    logic             col_b;
    logic [3:0][31:0] rd_b;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         clear_req = 1'b0;
  logic [1:0]   we = 2'b00;
  logic [63:0]  wdata = '0;
  logic [9:0]   waddr_a = '0;
  logic [9:0]   raddr_a = '0;
  logic [63:0]  rdata_a;
  logic         ready_a, coll_a;
  logic [7:0]   waddr_b = '0;
  logic [15:0]  raddr_b = '0;
  logic [127:0] rdata_b;
  logic         ready_b, coll_b;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  // Reference model: per DUT, register contents, cycles of clearing left,
  // and the collision flag to be shown in the next cycle.
  logic [31:0] m_regs [2][32];
  int          m_busy [2];
  bit          m_coll [2];
  // Current-cycle write inputs, per DUT (addresses already truncated).
  bit [1:0]    s_we;
  int          s_wa [2][2];
  logic [31:0] s_wd [2];

  always #5 clk = ~clk;

  regfile_multiport u_dut_a (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_a),
    .we(we), .waddr(waddr_a), .wdata(wdata), .raddr(raddr_a),
    .rdata(rdata_a), .collision(coll_a)
  );

  regfile_multiport #(.NREGS(16), .READ_PORTS(4), .BYPASS(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_b),
    .we(we), .waddr(waddr_b), .wdata(wdata), .raddr(raddr_b),
    .rdata(rdata_b), .collision(coll_b)
  );

  function automatic int nregs_of(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = nregs_of(d) - 1;
      m_coll[d] = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[d][i] = '0;
    end
  endfunction

  function automatic logic [31:0] exp_read(input int d, input int a);
    if (m_busy[d] != 0 || a == 0) return 32'h0;
    if (d == 0) begin
      if (s_we[1] && s_wa[0][1] == a) return s_wd[1];
      if (s_we[0] && s_wa[0][0] == a) return s_wd[0];
    end
    return m_regs[d][a];
  endfunction

  function automatic void model_edge(input int d, input bit creq);
    if (m_busy[d] != 0) begin
      m_coll[d] = 1'b0;
      m_busy[d] = creq ? nregs_of(d) - 1 : m_busy[d] - 1;
    end else begin
      m_coll[d] = !creq && s_we == 2'b11 && s_wa[d][0] == s_wa[d][1] && s_wa[d][0] != 0;
      if (s_we[0] && s_wa[d][0] != 0) m_regs[d][s_wa[d][0]] = s_wd[0];
      if (s_we[1] && s_wa[d][1] != 0) m_regs[d][s_wa[d][1]] = s_wd[1];
      if (creq) begin
        m_busy[d] = nregs_of(d) - 1;
        for (int i = 0; i < 32; i++) m_regs[d][i] = '0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, push the expected outputs
  // for this cycle, then advance the model across the rising edge.
  task automatic do_cycle(input bit rst_n, input bit creq, input bit [1:0] wen,
                          input int wa0, input int wa1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input int r0, input int r1, input int r2, input int r3);
    exp_t e;
    int   r [4];
    r = '{r0, r1, r2, r3};
    @(negedge clk);
    reset     = rst_n;
    clear_req = creq;
    we        = wen;
    wdata     = {d1, d0};
    waddr_a   = {wa1[4:0], wa0[4:0]};
    waddr_b   = {wa1[3:0], wa0[3:0]};
    raddr_a   = {r1[4:0], r0[4:0]};
    raddr_b   = {r3[3:0], r2[3:0], r1[3:0], r0[3:0]};
    s_we = wen;
    s_wa[0][0] = wa0 & 31; s_wa[0][1] = wa1 & 31;
    s_wa[1][0] = wa0 & 15; s_wa[1][1] = wa1 & 15;
    s_wd[0] = d0; s_wd[1] = d1;
    if (!rst_n) model_reset();
    #1;
    e.rdy_a = (m_busy[0] == 0);
    e.col_a = m_coll[0];
    e.rdy_b = (m_busy[1] == 0);
    e.col_b = m_coll[1];
    for (int j = 0; j < 2; j++) e.rd_a[j] = exp_read(0, r[j] & 31);
    for (int j = 0; j < 4; j++) e.rd_b[j] = exp_read(1, r[j] & 15);
    sb.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      model_edge(0, creq);
      model_edge(1, creq);
    end
  endtask

  task automatic idle(input int n, input int ra, input int rb);
    for (int i = 0; i < n; i++) do_cycle(1, 0, 2'b00, 0, 0, 0, 0, ra, rb, ra, rb);
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ready_a", {31'b0, ready_a}, {31'b0, e.rdy_a});
        check("collision_a", {31'b0, coll_a}, {31'b0, e.col_a});
        check("ready_b", {31'b0, ready_b}, {31'b0, e.rdy_b});
        check("collision_b", {31'b0, coll_b}, {31'b0, e.col_b});
        for (int j = 0; j < 2; j++)
          check($sformatf("rdata_a[%0d]", j), rdata_a[j*32 +: 32], e.rd_a[j]);
        for (int j = 0; j < 4; j++)
          check($sformatf("rdata_b[%0d]", j), rdata_b[j*32 +: 32], e.rd_b[j]);
      end
    end
  end

  initial begin : stimulus
    int a0, a1, ra, rb;
    // Reset, release, then the full clear (31 edges for A, 15 for B).
    repeat (3) do_cycle(0, 0, 2'b00, 0, 0, 0, 0, 1, 2, 3, 4);
    for (int i = 0; i < 33; i++) idle(1, i % 32, 31 - (i % 32));
    for (int a = 0; a < 32; a++) do_cycle(1, 0, 2'b00, 0, 0, 0, 0, a, 31 - a, (a + 5) % 32, a ^ 9);

    // Same-cycle bypass on x5 (A bypasses, B shows old then new).
    do_cycle(1, 0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 5, 5, 5, 5);
    idle(2, 5, 5);

    // Same-address collision on x7, then both ports writing x0.
    do_cycle(1, 0, 2'b11, 7, 7, 32'h11, 32'h22, 7, 7, 7, 7);
    idle(2, 7, 0);
    do_cycle(1, 0, 2'b11, 0, 0, 32'h33, 32'h44, 0, 0, 0, 0);
    idle(2, 0, 7);

    // Clear request with a write attempted during the clear.
    do_cycle(1, 0, 2'b01, 3, 0, 32'h1234, 0, 3, 3, 3, 3);
    do_cycle(1, 1, 2'b00, 0, 0, 0, 0, 3, 4, 3, 4);
    do_cycle(1, 0, 2'b01, 4, 0, 32'h5555, 0, 3, 4, 3, 4);
    idle(32, 3, 4);

    // Asynchronous reset mid-clear (clr_idx = 10), then a full re-clear.
    do_cycle(1, 0, 2'b10, 0, 9, 0, 32'h99, 9, 9, 9, 9);
    do_cycle(1, 1, 2'b00, 0, 0, 0, 0, 9, 1, 9, 1);
    idle(9, 9, 1);
    do_cycle(0, 0, 2'b00, 0, 0, 0, 0, 9, 1, 9, 1);
    do_cycle(0, 0, 2'b00, 0, 0, 0, 0, 9, 1, 9, 1);
    idle(32, 9, 1);

    // x15 on every port, then an asynchronous reset while ready.
    do_cycle(1, 0, 2'b01, 15, 0, 32'hA5A5A5A5, 0, 15, 15, 15, 15);
    idle(2, 15, 15);
    do_cycle(0, 0, 2'b00, 0, 0, 0, 0, 15, 15, 15, 15);
    idle(33, 15, 1);

    // Randomised traffic with occasional clear requests.
    for (int i = 0; i < 800; i++) begin
      a0 = $urandom_range(0, 31);
      a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 31);
      ra = ($urandom_range(0, 2) == 0) ? a0 : $urandom_range(0, 31);
      rb = ($urandom_range(0, 2) == 0) ? a1 : $urandom_range(0, 31);
      do_cycle(1, $urandom_range(0, 79) == 0, 2'($urandom), a0, a1, $urandom, $urandom,
               ra, rb, $urandom_range(0, 31), a0 ^ 16);
    end

    repeat (2) @(negedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
